// File: rtl/sar_search_16bit_if.sv
// Bus between the SAR search engine and the external magnitude comparator.
interface sar_search_16bit_if #(
    parameter int unsigned WIDTH = 16
) ();
    localparam int unsigned SW = $clog2(WIDTH + 1);

    logic             start;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [SW-1:0]    steps;
    logic             err;

    // Engine side: issues trials, consumes comparator flags.
    modport master (
        input  start, cmp_gt, cmp_eq, cmp_lt,
        output trial, busy, done, result, steps, err
    );

    // Requester/comparator side.
    modport slave (
        output start, cmp_gt, cmp_eq, cmp_lt,
        input  trial, busy, done, result, steps, err
    );
endinterface

// File: rtl/sar_search_16bit.sv
// Successive-approximation search: drives MSB-first trial values into an
// external comparator and converges on the hidden target from gt/eq/lt.
module sar_search_16bit #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CMP_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    sar_search_16bit_if.master bus
);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned SW = $clog2(WIDTH + 1);
    localparam int unsigned CW = (CMP_LAT > 1) ? $clog2(CMP_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    // With no comparator pipeline the flags are ready the cycle after a trial.
    localparam state_t TRIAL_STATE = (CMP_LAT != 0) ? WAIT : SAMPLE;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] bit_mask_c;
    logic [WIDTH-1:0] adj_trial_c;
    logic             flags_ok_c;

    // Current decision bit, trial with that bit resolved, and flag legality.
    always_comb begin
        bit_mask_c  = WIDTH'(1) << idx_q;
        adj_trial_c = bus.cmp_lt ? (trial_q & ~bit_mask_c) : trial_q;
        flags_ok_c  = $onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        steps_d  = steps_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    trial_d = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d   = IW'(WIDTH - 1);
                    steps_d = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(CMP_LAT);
                    state_d = TRIAL_STATE;
                end
            end

            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            SAMPLE: begin
                steps_d = steps_q + SW'(1);
                if (!flags_ok_c) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (bus.cmp_eq) begin
                    result_d = trial_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    result_d = adj_trial_c;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    trial_d = adj_trial_c | (bit_mask_c >> 1);
                    cnt_d   = CW'(CMP_LAT);
                    state_d = TRIAL_STATE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.trial  = trial_q;
    assign bus.result = result_q;
    assign bus.steps  = steps_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: doc/sar_search_16bit.md
Name: sar_search_16bit

Overview:
Successive-approximation search engine that drives the operand side of an external magnitude comparator. It is the initiator for a comparator that answers gt/eq/lt. It issues trial values MSB-first, consumes the comparator's gt/eq/lt answers, and converges on the hidden target operand. It is used to recover an unknown value (threshold, calibration code) that is only observable through comparison against a programmable value.

Parameters:
WIDTH, 16, operand width in bits
CMP_LAT, 1, idle cycles between a trial update and flag sampling (comparator pipeline depth, 0 allowed)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin a search; sampled only in IDLE
cmp_gt  input  1  comparator: target > trial
cmp_eq  input  1  comparator: target == trial
cmp_lt  input  1  comparator: target < trial
trial  output  WIDTH  registered trial value driven to comparator B input
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse, search finished
result  output  WIDTH  recovered target; held until next start
steps  output  $clog2(WIDTH+1)  number of comparisons used in the last search
err  output  1  last search aborted on illegal flags; held until next start

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- Reset values: trial=0, busy=0, done=0, result=0, steps=0, err=0, FSM=IDLE.
- rst during a search aborts it: on the next edge all outputs take their reset values, with no done pulse.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE: on the edge where start=1:
  - trial <= 1<<(WIDTH-1); bit index i <= WIDTH-1; steps <= 0; err <= 0; busy <= 1.
  - Wait counter <= CMP_LAT.
  - Next state is WAIT if CMP_LAT>0, else SAMPLE.
- WAIT: decrement the counter each cycle. Move to SAMPLE when the counter reaches 1.
  - Each trial therefore occupies exactly CMP_LAT+1 cycles, with the flags sampled on the edge that ends SAMPLE.
- SAMPLE: steps <= steps+1. Flags must be exactly one-hot.
  - eq: result <= trial; go DONE (early exit).
  - gt: keep bit i.
  - lt: clear bit i.
  - If i==0 after the gt/lt decision: result <= adjusted trial; go DONE.
  - Otherwise: i <= i-1; trial <= adjusted trial | (1<<(i-1)); reload the wait counter; go WAIT or SAMPLE as above.
- Illegal flags (none set, or more than one set) in SAMPLE: err <= 1; result <= 0; go DONE.
- DONE: done=1 and busy=0 for this single cycle; trial holds its last value; return to IDLE.
  - A start in DONE is ignored. start is accepted one cycle later, in IDLE.
- start while busy: ignored, with no effect on the search.
- Arithmetic: bit operations only; no carries.
- Completion length:
  - A nonzero target always terminates on eq, at the comparison whose trial equals the target.
  - Target 0 runs all WIDTH comparisons with lt and ends with result=0, steps=WIDTH.
- Latency, start edge to done pulse: steps*(CMP_LAT+1) cycles, plus 1 cycle in DONE.

Test Plan:
1. Target 0x0000, CMP_LAT=1 (bench comparator model with 1-cycle registered flags):
   - Trials are 0x8000, 0x4000, ..., 0x0001.
   - Required: result=0x0000, steps=16, err=0, done exactly 33 cycles after the start edge.
2. Target 0x0004:
   - Trials are 0x8000, 0x4000, ..., 0x0008, 0x0004 (eq).
   - Required: result=0x0004, steps=14, done pulse width 1.
3. Target 0xFFFF:
   - Trials are 0x8000, 0xC000, 0xE000, ..., 0xFFFF (eq).
   - Required: result=0xFFFF, steps=16.
   - Repeat with CMP_LAT=0: done 17 cycles after start.
4. Target 0xA5A5, with start pulsed again mid-search:
   - Required: the extra start is ignored, result=0xA5A5, steps=16.
   - A new start in the cycle after done returns busy=1 and starts a fresh search.
5. Bench forces cmp_gt=cmp_eq=cmp_lt=0 at the 3rd sample:
   - Required: err=1, result=0, steps=3, done pulse, busy=0.
   - The next start clears err.
6. rst asserted at step 5 of a search:
   - Required: on the next edge trial=0, busy=0, result=0, steps=0, no done pulse.
   - A subsequent search for 0x1234 completes correctly.
